// File: rtl/prince_ti_sbox_sched_pkg.sv
// Shared types and constants for the nibble-serial threshold-implemented PRINCE S-box scheduler.
// Holds the scheduler FSM encoding and the share/nibble geometry.
package prince_ti_pkg;

  localparam int NIB_W    = 4;
  localparam int STATE_W  = 64;
  localparam int N_SHARES = 3;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Select nibble idx of one share; idx comes only from a counter, never from share data.
  function automatic logic [NIB_W-1:0] nib_sel(input logic [STATE_W-1:0] s,
                                               input logic [3:0]         idx);
    nib_sel = s[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/prince_ti_sbox_sched_if.sv
// Bundle of the state-in, result-out and S-box pipeline signals of the scheduler.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1; valid never depends on ready.
interface prince_ti_sbox_sched_if;
  import prince_ti_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] in_s0;
  logic [STATE_W-1:0] in_s1;
  logic [STATE_W-1:0] in_s2;

  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] out_s0;
  logic [STATE_W-1:0] out_s1;
  logic [STATE_W-1:0] out_s2;

  logic               sb_in_valid;
  logic [NIB_W-1:0]   sb_in_s0;
  logic [NIB_W-1:0]   sb_in_s1;
  logic [NIB_W-1:0]   sb_in_s2;
  logic [NIB_W-1:0]   sb_out_s0;
  logic [NIB_W-1:0]   sb_out_s1;
  logic [NIB_W-1:0]   sb_out_s2;

  modport slave (
    input  in_valid, in_s0, in_s1, in_s2,
    output in_ready,
    output out_valid, out_s0, out_s1, out_s2,
    input  out_ready,
    output sb_in_valid, sb_in_s0, sb_in_s1, sb_in_s2,
    input  sb_out_s0, sb_out_s1, sb_out_s2
  );

  modport master (
    output in_valid, in_s0, in_s1, in_s2,
    input  in_ready,
    input  out_valid, out_s0, out_s1, out_s2,
    output out_ready,
    input  sb_in_valid, sb_in_s0, sb_in_s1, sb_in_s2,
    output sb_out_s0, sb_out_s1, sb_out_s2
  );

endinterface

// File: rtl/prince_ti_sbox_sched_ti_valid_delay.sv
// Delays the S-box issue strobe by the pipeline latency so results are captured exactly when they return.
// Clearing it on reset discards any nibbles still travelling through the external pipeline.
module ti_valid_delay #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic sb_in_valid,
  output logic cap_en
);

  logic [LAT-1:0] dly_q;

  generate
    if (LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) dly_q <= '0;
        else     dly_q <= sb_in_valid;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (rst) dly_q <= '0;
        else     dly_q <= {dly_q[LAT-2:0], sb_in_valid};
      end
    end
  endgenerate

  assign cap_en = dly_q[LAT-1];

endmodule

// File: rtl/prince_ti_sbox_sched.sv
// Nibble-serial scheduler: streams a 3-share 64-bit state through a shared S-box pipeline
// one nibble per share per cycle, then reassembles the returned nibbles into a 3-share result.
module prince_ti_sbox_sched
  import prince_ti_pkg::*;
#(
  parameter int NIB = 16,
  parameter int LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  prince_ti_sbox_sched_if.slave  bus,
  output logic                   busy,
  output state_t                 dbg_state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;
  logic [3:0]       rd_nxt;
  logic             sb_v_q;
  logic             cap_en, cap_go;
  logic             accept, feed_last, feed_more;

  // One register set per share; shares are only ever indexed by counters.
  logic [STATE_W-1:0] in_sh  [N_SHARES];
  logic [NIB_W-1:0]   out_sh [N_SHARES];
  logic [STATE_W-1:0] st_q   [N_SHARES];
  logic [STATE_W-1:0] res_q  [N_SHARES];
  logic [NIB_W-1:0]   sb_q   [N_SHARES];

  assign in_sh[0]  = bus.in_s0;
  assign in_sh[1]  = bus.in_s1;
  assign in_sh[2]  = bus.in_s2;
  assign out_sh[0] = bus.sb_out_s0;
  assign out_sh[1] = bus.sb_out_s1;
  assign out_sh[2] = bus.sb_out_s2;

  assign accept    = (state_q == ST_IDLE) && bus.in_valid;
  assign feed_last = (state_q == ST_FEED) && (rd_cnt == CNT_W'(NIB-1));
  assign feed_more = (state_q == ST_FEED) && !feed_last;
  assign cap_go    = cap_en && ((state_q == ST_FEED) || (state_q == ST_DRAIN));
  assign rd_nxt    = rd_cnt[3:0] + 4'd1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid) state_d = ST_FEED;
      ST_FEED:  if (feed_last) state_d = ST_DRAIN;
      ST_DRAIN: if (cap_go && (wr_cnt == CNT_W'(NIB-1))) state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      sb_v_q <= 1'b0;
    end else if (accept) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      sb_v_q <= 1'b1;
    end else begin
      if (state_q == ST_FEED) rd_cnt <= rd_cnt + CNT_W'(1);
      sb_v_q <= feed_more;
      if (cap_go) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

  // The S-box operands are registered one cycle ahead so sb_in_s* never glitch and read 0 when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_SHARES; k++) begin
        st_q[k]  <= '0;
        res_q[k] <= '0;
        sb_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < N_SHARES; k++) begin
        if (accept) st_q[k] <= in_sh[k];
        if (accept)         sb_q[k] <= in_sh[k][NIB_W-1:0];
        else if (feed_more) sb_q[k] <= nib_sel(st_q[k], rd_nxt);
        else                sb_q[k] <= '0;
        if (cap_go) res_q[k][wr_cnt[3:0]*NIB_W +: NIB_W] <= out_sh[k];
      end
    end
  end

  ti_valid_delay #(.LAT(LAT)) u_delay (
    .clk         (clk),
    .rst         (rst),
    .sb_in_valid (sb_v_q),
    .cap_en      (cap_en)
  );

  assign bus.in_ready    = (state_q == ST_IDLE);
  assign bus.out_valid   = (state_q == ST_DONE);
  assign bus.out_s0      = res_q[0];
  assign bus.out_s1      = res_q[1];
  assign bus.out_s2      = res_q[2];
  assign bus.sb_in_valid = sb_v_q;
  assign bus.sb_in_s0    = sb_q[0];
  assign bus.sb_in_s1    = sb_q[1];
  assign bus.sb_in_s2    = sb_q[2];
  assign busy            = (state_q != ST_IDLE);
  assign dbg_state       = state_q;

endmodule
